// File: rtl/alu_mem_bridge.sv
// Word-to-byte bridge between the ALU memory port and a byte-wide synchronous RAM.
// Each 32-bit request becomes four little-endian byte accesses, followed by a done pulse.
module alu_mem_bridge #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              readReq,
    input  logic              writeReq,
    input  logic [31:0]       ramAddress,
    input  logic [31:0]       ramOut,
    output logic [31:0]       ramValue,
    output logic              busy,
    output logic              done,
    output logic              addrErr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_TAIL = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state, nextState;
    logic [1:0]        idx, nextIdx;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wrData;
    logic [23:0]       rdBuf;
    logic              accept;

    assign accept = (state == IDLE) && (readReq || writeReq);

    always_comb begin
        nextState = state;
        nextIdx   = idx;
        case (state)
            IDLE: begin
                nextIdx = 2'd0;
                // A simultaneous read is dropped: the write takes priority.
                if (writeReq)     nextState = WR;
                else if (readReq) nextState = RD;
            end
            RD: begin
                nextIdx = idx + 2'd1;
                if (idx == 2'd3) nextState = RD_TAIL;
            end
            RD_TAIL: nextState = DONE;
            WR: begin
                nextIdx = idx + 2'd1;
                if (idx == 2'd3) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Strobes are gated by reset so an abort stops RAM traffic in the very cycle it is asserted.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = 8'h00;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        if (state == RD || state == WR) mem_addr = base + ADDR_W'(idx);
        if (state == RD) mem_re = reset;
        if (state == WR) begin
            mem_we    = reset;
            mem_wdata = wrData[{idx, 3'b000} +: 8];
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= 2'd0;
            base     <= '0;
            wrData   <= 32'h0;
            rdBuf    <= 24'h0;
            ramValue <= 32'h0;
            addrErr  <= 1'b0;
        end else begin
            state <= nextState;
            idx   <= nextIdx;
            if (accept) begin
                base   <= ramAddress[ADDR_W-1:0];
                wrData <= ramOut;
                if (|ramAddress[31:ADDR_W]) addrErr <= 1'b1;
            end
            // Read data lags the strobe by one cycle, so idx k collects byte k-1.
            if (state == RD) begin
                case (idx)
                    2'd1:    rdBuf[7:0]   <= mem_rdata;
                    2'd2:    rdBuf[15:8]  <= mem_rdata;
                    2'd3:    rdBuf[23:16] <= mem_rdata;
                    default: ;
                endcase
            end
            if (state == RD_TAIL) ramValue <= {mem_rdata, rdBuf};
        end
    end

endmodule

// File: tb/tb_alu_mem_bridge.sv
// Directed bench for alu_mem_bridge: byte RAM attached to the bridge, expected
// byte traffic queued per request and expected words hand-computed.
module tb_alu_mem_bridge;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              readReq, writeReq;
    logic [31:0]       ramAddress, ramOut;
    logic [31:0]       ramValue;
    logic              busy, done, addrErr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re, mem_we;
    logic [7:0]        mem_wdata, mem_rdata;

    logic [7:0] ram [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    // Expected write traffic as {addr, byte}; expected read traffic as addr.
    logic [ADDR_W+7:0] expWr[$];
    logic [ADDR_W-1:0] expRd[$];

    alu_mem_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .readReq(readReq), .writeReq(writeReq),
        .ramAddress(ramAddress), .ramOut(ramOut), .ramValue(ramValue),
        .busy(busy), .done(done), .addrErr(addrErr), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to done, checking each byte strobe and the done cycle.
    task automatic runReq(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input int expDone);
        int doneAt = 0;
        int reCnt  = 0;
        int both   = 0;
        @(negedge clk);
        readReq    = rd;
        writeReq   = wr;
        ramAddress = addr;
        ramOut     = data;
        @(posedge clk);
        #1;
        readReq  = 1'b0;
        writeReq = 1'b0;
        for (int n = 1; n <= 12 && doneAt == 0; n++) begin
            @(negedge clk);
            if (n == 1) check("busyAfterAccept", {31'b0, busy}, 32'h1);
            if (mem_re && mem_we) both++;
            if (mem_re) begin
                reCnt++;
                check("reAddr", {21'b0, mem_addr},
                      expRd.size() != 0 ? {21'b0, expRd.pop_front()} : 32'hFFFF_FFFF);
            end
            if (mem_we)
                check("weAddrData", {13'b0, mem_addr, mem_wdata},
                      expWr.size() != 0 ? {13'b0, expWr.pop_front()} : 32'hFFFF_FFFF);
            if (done) begin
                doneAt = n;
                check("busyInDone", {31'b0, busy}, 32'h1);
            end
        end
        check("doneCycle", doneAt, expDone);
        check("reWeOverlap", both, 0);
        check("trafficLeft", expWr.size() + expRd.size(), 0);
        if (wr) check("noReOnWrite", reCnt, 0);
    endtask

    initial begin
        logic flagBad;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
        reset      = 1'b0;
        readReq    = 1'b0;
        writeReq   = 1'b0;
        ramAddress = 32'h0;
        ramOut     = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstRamValue", ramValue, 32'h0);
        check("rstFlags", {28'b0, busy, done, addrErr, mem_re}, 32'h0);
        check("rstMem", {13'b0, mem_we, mem_addr, mem_wdata}, 32'h0);
        reset = 1'b1;

        // 1: write DEADBEEF at 0x010
        expWr = '{{11'h010, 8'hEF}, {11'h011, 8'hBE}, {11'h012, 8'hAD}, {11'h013, 8'hDE}};
        runReq(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5);
        check("t1RamValue", ramValue, 32'h0);

        // 2: read it back
        expRd = '{11'h010, 11'h011, 11'h012, 11'h013};
        runReq(1'b1, 1'b0, 32'h0000_0010, 32'h0, 6);
        check("t2RamValue", ramValue, 32'hDEAD_BEEF);
        check("t2AddrErr", {31'b0, addrErr}, 32'h0);

        // 3: wrap around the top of the RAM
        expWr = '{{11'h7FE, 8'h44}, {11'h7FF, 8'h33}, {11'h000, 8'h22}, {11'h001, 8'h11}};
        runReq(1'b0, 1'b1, 32'h0000_07FE, 32'h1122_3344, 5);
        check("t3RamHeld", ramValue, 32'hDEAD_BEEF);
        expRd = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        runReq(1'b1, 1'b0, 32'h0000_07FE, 32'h0, 6);
        check("t3RamValue", ramValue, 32'h1122_3344);

        // 4: out-of-range address truncates and sets the sticky error
        expRd = '{11'h000, 11'h001, 11'h002, 11'h003};
        runReq(1'b1, 1'b0, 32'h0000_0800, 32'h0, 6);
        check("t4AddrErr", {31'b0, addrErr}, 32'h1);
        check("t4RamValue", ramValue, 32'h0000_1122);

        // 5: read and write together, write wins
        expWr = '{{11'h020, 8'hA5}, {11'h021, 8'hA5}, {11'h022, 8'hA5}, {11'h023, 8'hA5}};
        runReq(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 5);
        check("t5AddrErrSticky", {31'b0, addrErr}, 32'h1);
        check("t5RamValue", ramValue, 32'h0000_1122);

        // 6: reset during the third byte of a write
        @(negedge clk);
        writeReq   = 1'b1;
        ramAddress = 32'h0000_0100;
        ramOut     = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        writeReq = 1'b0;
        repeat (3) @(negedge clk);
        check("t6InWr2", {20'b0, mem_we, mem_addr}, {20'b0, 1'b1, 11'h102});
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t6AfterRst", {28'b0, mem_we, busy, done, addrErr}, 32'h0);
        check("t6AfterRstRe", {31'b0, mem_re}, 32'h0);
        @(negedge clk);
        reset   = 1'b1;
        flagBad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || mem_we || mem_re || busy) flagBad = 1'b1;
        end
        check("t6Quiet", {31'b0, flagBad}, 32'h0);
        check("t6Bytes", {ram[11'h103], ram[11'h102], ram[11'h101], ram[11'h100]}, 32'h0000_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
